// File: rtl/intr_ctrl_4ch.sv
// Four-source interrupt controller: edge-latched pending bits, fixed priority
// (source 3 highest), irq/ack handshake with timeout and nested in-service tracking.
module intr_ctrl_4ch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] in_service
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] prev_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] isr_q, isr_d;
  logic [1:0] id_q, id_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] ack_set;
  logic [3:0] eoi_clr;

  // Sources strictly above the highest in-service level may nest.
  function automatic logic [3:0] above_of(input logic [3:0] isr);
    if (isr[3])      return 4'b0000;
    else if (isr[2]) return 4'b1000;
    else if (isr[1]) return 4'b1100;
    else if (isr[0]) return 4'b1110;
    else             return 4'b1111;
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [3:0] top_bit(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  assign rise     = irq_in & ~prev_q;
  assign eligible = pending_q & ~mask & above_of(isr_q);
  assign eoi_clr  = eoi ? top_bit(isr_q) : 4'b0000;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ack_set = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = encode(eligible);
          cnt_d   = 8'd0;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_set = 4'b0001 << id_q;
          state_d = GAP;
        end else if (!eligible[id_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A rise in the ack cycle wins over the clear.
    pending_d = (pending_q & ~ack_set) | rise;
    isr_d     = (isr_q & ~eoi_clr) | ack_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= 4'b0000;
      pending_q <= 4'b0000;
      isr_q     <= 4'b0000;
      id_q      <= 2'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= irq_in;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq        = (state_q == REQ);
  assign irq_id     = id_q;
  assign pending    = pending_q;
  assign in_service = isr_q;

endmodule

// File: doc/intr_ctrl_4ch.md
# intr_ctrl_4ch

Four-source interrupt controller that turns rising edges on raw request lines into latched pending bits and arbitrates them. It uses fixed priority, with source 3 highest. It presents one request at a time to the CPU side over an irq/ack handshake and tracks nested in-service levels until end-of-interrupt. It sits between peripheral event lines and the CPU, and supplies the sequencing, latching and masking around a 4-to-2 priority encode.

## Interface
- TIMEOUT, 15: cycles irq may stay asserted without irq_ack before the controller withdraws it (range 1..255).
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  4  raw event lines, synchronous to clk; rising edge = event.
- mask  in  4  1 = source blocked from arbitration (pending still latches).
- irq_ack  in  1  CPU accepts the presented request; single-cycle pulse.
- eoi  in  1  end-of-interrupt; single-cycle pulse.
- irq  out  1  request to CPU.
- irq_id  out  2  source number presented; valid only while irq=1.
- pending  out  4  latched, not-yet-acknowledged events.
- in_service  out  4  acknowledged, not-yet-ended sources.

## Operation
- Reset values: irq=0, irq_id=00, pending=0000, in_service=0000, edge-history register=0000, timeout counter=0, state IDLE.
- Edge detection uses rise = irq_in & ~prev, where prev is irq_in registered. A line already high at reset release counts as a rise on the first clock.
- pending[i] is set on rise[i]. It is cleared when irq_ack accepts id i. If a set and a clear hit the same bit in the same cycle, the set wins and pending stays 1.
- Eligibility: eligible = pending & ~mask & above. above has bit i high when i is greater than the highest set bit of in_service, or all ones when in_service = 0.
- The priority encode of eligible selects the highest index. This allows nesting: a higher source can preempt an in-service lower one.
- FSM states:
  - IDLE: irq=0. If eligible≠0, go to REQ. On that edge, load irq_id = encode(eligible), clear the counter, and set irq=1.
  - REQ: irq=1 and irq_id is held stable. A newly eligible higher source does not change irq_id.
    - On irq_ack: clear pending[irq_id], set in_service[irq_id], set irq=0, go to GAP.
    - Else if the presented source is no longer eligible (mask set): irq=0, go to IDLE.
    - Else if the counter reaches TIMEOUT-1: irq=0, go to IDLE, pending unchanged.
    - Otherwise the counter increments.
  - GAP: one cycle with irq=0, then go to IDLE. This guarantees irq drops for at least one cycle between requests.
- irq_ack outside REQ is ignored.
- eoi clears the highest set bit of the registered in_service value. eoi with in_service=0 is ignored.
- eoi is legal in any state. It is applied in the same cycle as an ack; the ack sets a bit strictly above the highest existing in-service bit, so the two never touch the same bit.
- A masked source keeps its pending bit indefinitely. It becomes presentable once unmasked.
- Repeated rises on an already-pending source merge into the single pending bit.

## Timing
- Event latency:
  - Edge E0 samples irq_in high after low at E-1.
  - pending is set after E0.
  - irq=1 with valid irq_id after E1, the earliest case.
- irq_ack sampled at edge En:
  - irq low, pending cleared and in_service set after En.
  - irq can reassert no earlier than after En+2 (GAP, then IDLE).
- Timeout: irq stays high for exactly TIMEOUT cycles when no ack arrives.
- Withdrawal on mask: irq low the cycle after mask[irq_id] is sampled high.
- eoi sampled at edge E: in_service is updated after E. A lower pending source can be presented after E+1 at the earliest.
- Asynchronous reset mid-request drops irq immediately. Pending and in-service history is lost.

## Test plan
- Single event: pulse irq_in=0100 → pending=0100 next cycle, irq=1 and irq_id=10 one cycle later. Ack → pending=0000, in_service=0100, irq=0. eoi → in_service=0000.
- Simultaneous events: irq_in 0000→1011 → irq_id=11 first. After ack, with no eoi, irq_id=01 is not presented because 1 is below in_service bit 3. eoi → irq_id=01, then 00 after the next ack/eoi.
- Nesting: source 1 in service, rise on source 2 → irq_id=10 presented and acked, in_service=0110. eoi → 0010. eoi → 0000.
- Mask: mask=1000, event on 3 → pending=1000, irq stays 0. Unmask → irq_id=11. Masking during REQ drops irq the next cycle.
- Timeout: with TIMEOUT=4 and no ack → irq high exactly 4 cycles, low 1 cycle, then re-presented with pending intact.
- Corner cases:
  - Rise on the acked source in the ack cycle → pending bit stays 1.
  - irq_ack in IDLE → no state change.
  - rst_n asserted mid-REQ → all outputs 0 immediately.
